// File: rtl/pc_unit_if.sv
// ---------------------------------------------------------------------------
// pc_unit_if
//   Bundles the redirect/fetch handshake of the program-counter unit.
//   master : resolve/fetch side. Drives redirect_*, fetch_ready, stall and
//            trap_ack, and observes pc, pc_valid, pc_next_seq,
//            misalign_trap, bad_addr and fetch_count.
//   slave  : the pc_unit itself.
// ---------------------------------------------------------------------------
interface pc_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             fetch_ready;
    logic             stall;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_base;
    logic [XLEN-1:0]  redirect_offset;
    logic             redirect_jalr;
    logic             trap_ack;

    logic [XLEN-1:0]  pc;
    logic             pc_valid;
    logic [XLEN-1:0]  pc_next_seq;
    logic             misalign_trap;
    logic [XLEN-1:0]  bad_addr;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        output fetch_ready, stall, redirect_valid, redirect_base,
               redirect_offset, redirect_jalr, trap_ack,
        input  pc, pc_valid, pc_next_seq, misalign_trap, bad_addr, fetch_count
    );

    modport slave (
        input  fetch_ready, stall, redirect_valid, redirect_base,
               redirect_offset, redirect_jalr, trap_ack,
        output pc, pc_valid, pc_next_seq, misalign_trap, bad_addr, fetch_count
    );
endinterface

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//   Program counter for the fetch stage. It holds the PC and advances it by
//   one instruction when fetch accepts. It also loads branch/jump targets
//   (base + offset) and catches misaligned targets. A misaligned target
//   either raises a trap or, in mask mode, has its low bits cleared. The
//   unit counts accepted fetches in a saturating counter.
//
// Ports
//   clk, rst      : clock (rising edge) and asynchronous active-high reset
//   bus (slave)   : fetch_ready, stall      - fetch handshake / pipeline hold
//                   redirect_valid/base/offset/jalr - taken branch or jump
//                   trap_ack                - handler accepts a misalign trap
//                   pc, pc_valid            - current fetch address
//                   pc_next_seq             - pc + instruction size (comb)
//                   misalign_trap, bad_addr - pending trap and its target
//                   fetch_count             - saturating accepted-fetch count
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter int              ALIGN_BITS   = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter bit              MASK_MODE    = 1'b0,
    parameter int              CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    pc_if.slave  bus
);

    // Instruction size in bytes, and the low-bit mask that must be zero
    // for an aligned address.
    localparam logic [XLEN-1:0] STEP     = XLEN'(1) << ALIGN_BITS;
    localparam logic [XLEN-1:0] LOW_MASK = STEP - XLEN'(1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [XLEN-1:0]  pc_q,       pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             trap_q,     trap_d;
    logic [XLEN-1:0]  bad_addr_q, bad_addr_d;
    logic [CNT_W-1:0] count_q,    count_d;

    logic [XLEN-1:0]  target_sum;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  pc_seq;
    logic             misaligned;
    logic             accept;

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    always_comb begin
        target_sum = bus.redirect_base + bus.redirect_offset;
        // jalr clears bit 0 before the alignment check. This lets a 2-byte
        // aligned machine take an odd rs1+imm without trapping.
        target     = bus.redirect_jalr ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
        misaligned = |(target & LOW_MASK);
        pc_seq     = pc_q + STEP;
        // pc_valid is exactly (state==RUN), so an accepted fetch is a RUN cycle
        // with fetch_ready and no stall. This holds even when a redirect wins
        // the pc update in the same cycle.
        accept     = (state_q == RUN) && bus.fetch_ready && !bus.stall;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        trap_d     = trap_q;
        bad_addr_d = bad_addr_q;
        count_d    = count_q;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end

            RUN: begin
                // A redirect overrides stall and fetch_ready.
                if (bus.redirect_valid) begin
                    if (!misaligned) begin
                        pc_d = target;
                    end else if (MASK_MODE) begin
                        pc_d = target & ~LOW_MASK;
                    end else begin
                        // pc is frozen. The handler restarts at TRAP_VECTOR.
                        state_d    = TRAP;
                        trap_d     = 1'b1;
                        bad_addr_d = target;
                    end
                end else if (accept) begin
                    pc_d = pc_seq;
                end

                if (accept && !(&count_q)) begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            TRAP: begin
                // bad_addr is kept so the handler can still read it after acking.
                if (bus.trap_ack) begin
                    pc_d    = TRAP_VECTOR;
                    trap_d  = 1'b0;
                    state_d = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase

        pc_valid_d = (state_d == RUN);
    end

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            trap_q     <= 1'b0;
            bad_addr_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            trap_q     <= trap_d;
            bad_addr_q <= bad_addr_d;
            count_q    <= count_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.pc_next_seq   = pc_seq;
    assign bus.misalign_trap = trap_q;
    assign bus.bad_addr      = bad_addr_q;
    assign bus.fetch_count   = count_q;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//   Two pc_unit instances receive identical stimulus:
//     u0 : ALIGN_BITS=2, trap mode, 16-bit counter
//     u1 : ALIGN_BITS=1, mask mode, 2-bit counter
//   A behavioural model tracks each instance. It is checked after every edge.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fr, stall, rv, jalr, ack;
    logic [31:0] base, off;

    always #5 clk = ~clk;

    pc_if #(.XLEN(32), .CNT_W(16)) b0 ();
    pc_if #(.XLEN(32), .CNT_W(2))  b1 ();

    assign b0.fetch_ready = fr;    assign b1.fetch_ready = fr;
    assign b0.stall = stall;       assign b1.stall = stall;
    assign b0.redirect_valid = rv; assign b1.redirect_valid = rv;
    assign b0.redirect_base = base;   assign b1.redirect_base = base;
    assign b0.redirect_offset = off;  assign b1.redirect_offset = off;
    assign b0.redirect_jalr = jalr;   assign b1.redirect_jalr = jalr;
    assign b0.trap_ack = ack;      assign b1.trap_ack = ack;

    pc_unit #(.XLEN(32), .ALIGN_BITS(2), .MASK_MODE(1'b0), .CNT_W(16))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    pc_unit #(.XLEN(32), .ALIGN_BITS(1), .MASK_MODE(1'b1), .CNT_W(2))
        u1 (.clk(clk), .rst(rst), .bus(b1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode codes: 0 = booting, 1 = running, 2 = waiting for trap_ack.
    int          m_ab  [2] = '{2, 1};
    bit          m_mask[2] = '{1'b0, 1'b1};
    int          m_cmax[2] = '{65535, 3};
    int          m_mode[2];
    logic [31:0] m_pc  [2];
    logic [31:0] m_bad [2];
    int          m_cnt [2];

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_pc[i] = 32'h0; m_bad[i] = 32'h0; m_cnt[i] = 0;
        end
    endtask

    task automatic m_step();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] t, sz;
            bit took;
            sz = 32'd1 << m_ab[i];
            if (m_mode[i] == 0) begin
                m_mode[i] = 1;
            end else if (m_mode[i] == 1) begin
                took = fr && !stall;
                t = base + off;
                if (jalr) t = t & ~32'd1;
                if (rv) begin
                    if (t % sz == 0)     m_pc[i] = t;
                    else if (m_mask[i])  m_pc[i] = t - (t % sz);
                    else begin m_mode[i] = 2; m_bad[i] = t; end
                end else if (took) begin
                    m_pc[i] = m_pc[i] + sz;
                end
                if (took && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
            end else if (ack) begin
                m_pc[i] = 32'h100;
                m_mode[i] = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc0"},    b0.pc,                  m_pc[0]);
        chk({tag, ".vld0"},   32'(b0.pc_valid),       32'(m_mode[0] == 1));
        chk({tag, ".nseq0"},  b0.pc_next_seq,         m_pc[0] + 32'd4);
        chk({tag, ".trap0"},  32'(b0.misalign_trap),  32'(m_mode[0] == 2));
        chk({tag, ".bad0"},   b0.bad_addr,            m_bad[0]);
        chk({tag, ".cnt0"},   32'(b0.fetch_count),    32'(m_cnt[0]));
        chk({tag, ".pc1"},    b1.pc,                  m_pc[1]);
        chk({tag, ".vld1"},   32'(b1.pc_valid),       32'(m_mode[1] == 1));
        chk({tag, ".nseq1"},  b1.pc_next_seq,         m_pc[1] + 32'd2);
        chk({tag, ".trap1"},  32'(b1.misalign_trap),  32'(m_mode[1] == 2));
        chk({tag, ".bad1"},   b1.bad_addr,            m_bad[1]);
        chk({tag, ".cnt1"},   32'(b1.fetch_count),    32'(m_cnt[1]));
    endtask

    task automatic idle();
        fr = 0; stall = 0; rv = 0; jalr = 0; ack = 0; base = 0; off = 0;
    endtask

    task automatic step(input string tag);
        m_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asserted mid-cycle, so the check shows the asynchronous clear.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_reset();
        check_all("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("rst_rel");
    endtask

    task automatic redir(input logic [31:0] b, input logic [31:0] o, input logic j, input string tag);
        rv = 1; base = b; off = o; jalr = j;
        step(tag);
        idle();
    endtask

    initial begin
        idle();
        do_reset();

        // 1: sequential fetch from reset
        fr = 1;
        step("t1_boot");
        chk("t1_vld_c1", 32'(b0.pc_valid), 32'd1);
        for (int k = 0; k < 3; k++) step("t1_seq");
        chk("t1_pc", b0.pc, 32'hC);
        chk("t1_cnt", 32'(b0.fetch_count), 32'd3);
        idle();

        // 2: redirect overrides stall
        redir(32'h10, 32'h0, 1'b0, "t2_set");
        stall = 1; fr = 1;
        redir(32'h10, 32'hFFFF_FFF8, 1'b0, "t2_back");
        chk("t2_pc", b0.pc, 32'h8);

        // 3: aligned target, then misaligned trap and ack
        redir(32'h3, 32'h5, 1'b0, "t3_al");
        chk("t3_pc", b0.pc, 32'h8);
        redir(32'h4, 32'h2, 1'b0, "t3_mis");
        chk("t3_trap", 32'(b0.misalign_trap), 32'd1);
        chk("t3_bad", b0.bad_addr, 32'h6);
        chk("t3_mask_pc", b1.pc, 32'h6);
        fr = 1; rv = 1; base = 32'h40;
        step("t3_intrap");
        idle();
        ack = 1;
        step("t3_ack");
        chk("t3_tv", b0.pc, 32'h100);
        idle();

        // 4: jalr bit-0 clearing
        redir(32'h1001, 32'h0, 1'b1, "t4_j1");
        chk("t4_pc1", b1.pc, 32'h1000);
        redir(32'h1002, 32'h0, 1'b1, "t4_j2");
        chk("t4_trap0", 32'(b0.misalign_trap), 32'd1);
        ack = 1; step("t4_ack"); idle();

        // 5: wrapping targets and sequential wrap
        redir(32'hFFFF_FFFF, 32'h1, 1'b0, "t5_wrapt");
        redir(32'h5, 32'h0, 1'b0, "t5_mask");
        chk("t5_mask_pc", b1.pc, 32'h4);
        ack = 1; step("t5_ack"); idle();
        redir(32'hFFFF_FFFC, 32'h0, 1'b0, "t5_top");
        fr = 1;
        step("t5_adv");
        chk("t5_wrap0", b0.pc, 32'h0);
        step("t5_adv2");
        chk("t5_wrap1", b1.pc, 32'h0);
        idle();

        // 6: reset during trap, counter saturation
        fr = 1;
        redir(32'h6, 32'h0, 1'b0, "t6_trap");
        step("t6_hold");
        do_reset();
        fr = 1;
        for (int k = 0; k < 6; k++) step("t6_sat");
        chk("t6_sat1", 32'(b1.fetch_count), 32'd3);
        idle();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                idle();
                do_reset();
            end
            fr    = ($urandom_range(0, 9) < 7);
            stall = ($urandom_range(0, 4) == 0);
            rv    = ($urandom_range(0, 3) == 0);
            jalr  = $urandom_range(0, 1);
            ack   = ($urandom_range(0, 2) == 0);
            base  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
            off   = 32'($urandom_range(0, 31)) - 32'd16;
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
